// File: rtl/lfsr_rng_bank.sv
// Purpose: bank of NCHAN Fibonacci LFSRs giving a serial pseudorandom bit per channel per step,
//          also packed into OUT_BITS-wide words per channel.
// Latency: r is registered one cycle after the step; a word is presented OUT_BITS steps after the previous one.
// Backpressure: while out_valid && !out_ready every LFSR, r and the word counter hold; out_data is stable.
//
// Ports:
//   CLK, nRST        clock (rising edge) and synchronous active-low reset
//   en               step enable
//   r                registered serial bit per channel (bit i = channel i)
//   seed_load/_chan  single-cycle reseed strobe and the channel it targets
//   seed_value       new state for the selected channel (zero is replaced by 1)
//   out_valid/ready  valid/ready handshake for the packed words
//   out_data         channel i occupies bits [i*OUT_BITS +: OUT_BITS], first bit in the MSB
module lfsr_rng_bank #(
    parameter int          WIDTH    = 64,
    parameter logic [63:0] TAPS     = 64'hD800000000000000,
    parameter int          NCHAN    = 4,
    parameter int          OUT_BITS = 8,
    parameter logic [63:0] SEED     = 64'hFEEDBABEDEADBEEF,
    localparam int         CW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      en,
    output logic [NCHAN-1:0]          r,
    input  logic                      seed_load,
    input  logic [CW-1:0]             seed_chan,
    input  logic [WIDTH-1:0]          seed_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCHAN*OUT_BITS-1:0] out_data
);

    localparam int               CNTW     = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(OUT_BITS - 1);
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

    logic                      stall;
    logic                      step;
    logic                      last;
    logic [CNTW-1:0]           cnt;
    logic [NCHAN-1:0]          msb;
    logic [NCHAN*OUT_BITS-1:0] word_nxt;
    logic [WIDTH-1:0]          seed_nz;

    assign stall   = out_valid && !out_ready;
    assign step    = en && !stall;
    assign last    = (cnt == CNT_LAST);
    // Loading zero would lock a channel up forever, so it is replaced by 1.
    assign seed_nz = (seed_value == '0) ? WIDTH'(1) : seed_value;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        // Per-channel reset seed: base seed XOR channel index, never zero.
        localparam logic [WIDTH-1:0] RST_RAW = SEED[WIDTH-1:0] ^ WIDTH'(i);
        localparam logic [WIDTH-1:0] RST_VAL = (RST_RAW == '0) ? WIDTH'(1) : RST_RAW;

        logic [WIDTH-1:0]    state;
        logic [OUT_BITS-1:0] acc;
        logic                fb;
        logic                hit;

        assign fb     = ^(state & TAP_MASK);
        // A single channel has nothing to select, so the channel field is don't-care.
        assign hit    = seed_load && ((NCHAN == 1) || (seed_chan == CW'(i)));
        assign msb[i] = state[WIDTH-1];
        // Shift the pre-shift MSB in at the bottom; the oldest bit ends up in the word MSB.
        assign word_nxt[i*OUT_BITS +: OUT_BITS] = OUT_BITS'({acc, state[WIDTH-1]});

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                state <= RST_VAL;
                acc   <= '0;
            end else begin
                // The reload wins over the shift, but the old MSB is still emitted below.
                if (hit) begin
                    state <= seed_nz;
                end else if (step) begin
                    state <= {state[WIDTH-2:0], fb};
                end
                if (step) begin
                    acc <= word_nxt[i*OUT_BITS +: OUT_BITS];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt       <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (step) begin
                r <= msb;
                if (last) begin
                    // A word completing in the transfer cycle keeps valid high with new data.
                    cnt       <= '0;
                    out_data  <= word_nxt;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_bank.sv
module tb_lfsr_rng_bank;

    logic        CLK = 1'b0;
    logic        nRST;

    logic        a_en;
    logic [3:0]  a_r;
    logic        a_seed_load;
    logic [1:0]  a_seed_chan;
    logic [63:0] a_seed_value;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] a_out_data;

    logic        b_en;
    logic [2:0]  b_r;
    logic        b_seed_load;
    logic [1:0]  b_seed_chan;
    logic [3:0]  b_seed_value;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [2:0]  b_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] b0tab [4];

    always #5 CLK = ~CLK;

    lfsr_rng_bank u_a (
        .CLK(CLK), .nRST(nRST), .en(a_en), .r(a_r),
        .seed_load(a_seed_load), .seed_chan(a_seed_chan), .seed_value(a_seed_value),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    lfsr_rng_bank #(
        .WIDTH(4), .TAPS(64'hC), .NCHAN(3), .OUT_BITS(1), .SEED(64'h1)
    ) u_b (
        .CLK(CLK), .nRST(nRST), .en(b_en), .r(b_r),
        .seed_load(b_seed_load), .seed_chan(b_seed_chan), .seed_value(b_seed_value),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bit k (0 = first emitted) of a byte emitted MSB first.
    function automatic logic bit_of(input logic [7:0] b, input int k);
        logic [7:0] t;
        t = b >> (7 - k);
        return t[0];
    endfunction

    function automatic logic a_rbit(input int c);
        logic [3:0] t;
        t = a_r >> c;
        return t[0];
    endfunction

    // MSB sequence of the 4-bit LFSR (taps 3,2) from state 1:
    // states 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8 -> MSBs 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1
    function automatic logic pbit(input int k);
        logic [14:0] t;
        t = 15'h7AC8 >> (k % 15);
        return t[0];
    endfunction

    // Run one 8-step word on instance A, checking channel rc's serial bits against rb,
    // optionally reseeding on the completing step.
    task automatic run_word(input string tag, input int rc, input logic [7:0] rb,
                            input logic do_seed, input logic [1:0] sc, input logic [63:0] sv);
        for (int k = 0; k < 8; k++) begin
            if (do_seed && k == 7) begin
                a_seed_load  = 1'b1;
                a_seed_chan  = sc;
                a_seed_value = sv;
            end
            tick();
            a_seed_load = 1'b0;
            check({tag, "_r"}, 64'(a_rbit(rc)), 64'(bit_of(rb, k)));
            if (k < 7) check({tag, "_vld_lo"}, 64'(a_out_valid), 64'd0);
        end
        check({tag, "_vld_hi"}, 64'(a_out_valid), 64'd1);
    endtask

    initial begin
        b0tab[0] = 8'hDE; b0tab[1] = 8'hAD; b0tab[2] = 8'hBE; b0tab[3] = 8'hEF;
        nRST = 1'b0;
        a_en = 1'b0; a_seed_load = 1'b0; a_seed_chan = '0; a_seed_value = '0; a_out_ready = 1'b1;
        b_en = 1'b0; b_seed_load = 1'b0; b_seed_chan = '0; b_seed_value = '0; b_out_ready = 1'b1;
        tick();
        tick();
        check("a_rst_r",    64'(a_r),         64'd0);
        check("a_rst_vld",  64'(a_out_valid), 64'd0);
        check("a_rst_data", 64'(a_out_data),  64'd0);
        check("b_rst_r",    64'(b_r),         64'd0);
        check("b_rst_vld",  64'(b_out_valid), 64'd0);
        check("b_rst_data", 64'(b_out_data),  64'd0);

        // First word: top byte of every channel's seed is FE.
        nRST = 1'b1;
        a_en = 1'b1;
        run_word("a_w1", 0, 8'hFE, 1'b0, 2'd0, 64'd0);
        check("a_w1_data", 64'(a_out_data), 64'hFEFEFEFE);

        // Stall for 20 cycles; channel 3 is reseeded mid-stall.
        a_out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                a_seed_load  = 1'b1;
                a_seed_chan  = 2'd3;
                a_seed_value = 64'h5A00_0000_0000_0000;
            end
            tick();
            a_seed_load = 1'b0;
            check("a_stall_vld",  64'(a_out_valid), 64'd1);
            check("a_stall_data", 64'(a_out_data),  64'hFEFEFEFE);
            check("a_stall_r",    64'(a_r),         64'd0);
        end
        a_out_ready = 1'b1;

        run_word("a_w2", 0, 8'hED, 1'b0, 2'd0, 64'd0);
        check("a_w2_data", 64'(a_out_data), 64'h5AEDEDED);

        // Reseed channel 1 on the completing step: this word still carries the old bits.
        run_word("a_w3", 1, 8'hBA, 1'b1, 2'd1, 64'hA5C3_0000_0000_0000);
        check("a_w3_data", 64'(a_out_data), 64'h00BABABA);
        check("a_w3_r",    64'(a_r),        64'h0);

        // Channel 1 now streams the new seed; zero-reseed channel 2 on the completing step.
        run_word("a_w4", 1, 8'hA5, 1'b1, 2'd2, 64'd0);
        check("a_w4_data", 64'(a_out_data), 64'h00BEA5BE);
        check("a_w4_r",    64'(a_r),        64'h2);

        // Channel 2 was loaded with 1: 63 zero bits, then a one.
        for (int w = 5; w <= 12; w++) begin
            if (w <= 8) run_word("a_wn_ch0", 0, b0tab[w-5], 1'b0, 2'd0, 64'd0);
            else        run_word("a_wn_ch2", 2, (w == 12) ? 8'h01 : 8'h00, 1'b0, 2'd0, 64'd0);
            check("a_wn_ch2_data", 64'(a_out_data[23:16]), (w == 12) ? 64'h01 : 64'h00);
            if (w <= 8)  check("a_wn_ch0_data", 64'(a_out_data[7:0]), 64'(b0tab[w-5]));
            if (w <= 11) check("a_wn_ch1_data", 64'(a_out_data[15:8]), (w == 5) ? 64'hC3 : 64'h00);
        end

        // Reset mid-word (cnt = 5) while stepping and reseeding: reset wins.
        for (int i = 0; i < 5; i++) tick();
        nRST         = 1'b0;
        a_seed_load  = 1'b1;
        a_seed_chan  = 2'd0;
        a_seed_value = 64'h1234;
        a_out_ready  = 1'b0;
        tick();
        check("a_mrst_r",    64'(a_r),         64'd0);
        check("a_mrst_vld",  64'(a_out_valid), 64'd0);
        check("a_mrst_data", 64'(a_out_data),  64'd0);
        nRST        = 1'b1;
        a_seed_load = 1'b0;
        a_out_ready = 1'b1;
        run_word("a_mrst_w1", 0, 8'hFE, 1'b0, 2'd0, 64'd0);
        check("a_mrst_w1_data", 64'(a_out_data), 64'hFEFEFEFE);
        a_en = 1'b0;

        // Small instance: channels 0 and 1 start at state 1 (1^1 = 0 becomes 1), channel 2 at 3.
        b_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            logic e2;
            b_seed_load = 1'b0;
            if (k == 30) begin
                b_seed_load  = 1'b1;
                b_seed_chan  = 2'd2;
                b_seed_value = 4'h0;
            end else if (k == 35) begin
                b_seed_load  = 1'b1;
                b_seed_chan  = 2'd3;
                b_seed_value = 4'h5;
            end
            tick();
            b_seed_load = 1'b0;
            e2 = (k <= 30) ? pbit(k + 4) : pbit(k - 31);
            check("b_r",    64'(b_r),         64'({e2, pbit(k), pbit(k)}));
            check("b_data", 64'(b_out_data),  64'({e2, pbit(k), pbit(k)}));
            check("b_vld",  64'(b_out_valid), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_bank.md
Name: lfsr_rng_bank

Overview:
- Multi-channel, width-parametrised Fibonacci LFSR pseudorandom source for the stochastic-bitstream datapath.
- Supplies NCHAN independent serial bitstreams every enabled cycle.
- Also packs each channel's bits into OUT_BITS-wide words, delivered over a valid/ready interface with backpressure.
- Supports runtime per-channel reseeding and blocks the all-zero lock-up state.

Parameters:
WIDTH, 64, LFSR state width in bits (4..64)
TAPS, 64'hD800000000000000, feedback tap mask; bit k set means state[k] is XORed into the feedback (default taps bits 63,62,60,59)
NCHAN, 4, number of independent LFSR channels (1..16)
OUT_BITS, 8, bits per packed output word per channel (1..32)
SEED, 64'hFEEDBABEDEADBEEF, base reset seed; truncated to WIDTH LSBs

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, synchronous, active-low
en  input  1  step enable
r  output  NCHAN  registered serial bit per channel (bit i = channel i)
seed_load  input  1  reseed strobe, single cycle
seed_chan  input  $clog2(NCHAN) or 1  channel selected for reseed
seed_value  input  WIDTH  new state for the selected channel
out_valid  output  1  packed word available
out_ready  input  1  consumer accepts word
out_data  output  NCHAN*OUT_BITS  packed words; channel i occupies bits [i*OUT_BITS +: OUT_BITS]

Behaviour:
- Reset (nRST=0 at posedge):
  - state_i <= SEED[WIDTH-1:0] ^ i; a zero result is replaced by 1.
  - cnt <= 0, accumulators <= 0, r <= 0, out_valid <= 0, out_data <= 0.
  - Reset overrides every other input, including mid-word and mid-reseed.
- stall = out_valid & ~out_ready; step = en & ~stall.
- On step, for every channel i:
  - fb_i = XOR-reduce(state_i & TAPS[WIDTH-1:0]).
  - state_i <= {state_i[WIDTH-2:0], fb_i}.
  - r[i] <= state_i[WIDTH-1], which is the pre-shift MSB.
  - acc_i <= {acc_i[OUT_BITS-2:0], state_i[WIDTH-1]}, so the first bit lands in the word MSB.
- No step: state, r, acc and cnt all hold.
- Shared counter cnt, range 0..OUT_BITS-1, advances on each step.
- On the step where cnt == OUT_BITS-1:
  - out_data slice i <= {acc_i[OUT_BITS-2:0], state_i[WIDTH-1]}.
  - out_valid <= 1, cnt <= 0.
- First word appears OUT_BITS enabled cycles after reset. Steady-state rate is one word per OUT_BITS cycles.
- Handshake:
  - A word is transferred on a cycle with out_valid & out_ready.
  - out_valid falls the cycle after the transfer, unless a new word completes in that same cycle, in which case it stays 1 with the new data.
  - While out_valid=1 and out_ready=0: out_data is stable, LFSRs stall, r holds. No word is ever dropped or overwritten.
- Reseed, on a cycle with seed_load=1:
  - state_{seed_chan} <= seed_value; a zero value is replaced by 1.
  - This load takes priority over the shift for that channel.
  - If step=1 in the same cycle, that channel still emits its old state MSB into r and acc, and cnt advances normally.
  - Other channels are unaffected.
  - seed_chan >= NCHAN: ignored.
  - Reseed is accepted even during a stall.
- All-zero state is therefore unreachable; no lock-up recovery is needed.
- NCHAN=1: seed_chan is 1 bit and ignored.
- OUT_BITS=1: a word completes on every step.

Test Plan:
- Reset with defaults, then en=1, out_ready=1 -> for 8 cycles r[0] = 1,1,1,1,1,1,1,0; the first out_valid carries channel 0 = 8'hFE and channel 1 = 8'hFE; out_valid is 0 during cycles 1-7.
- WIDTH=4, TAPS=4'b1100, NCHAN=1, SEED=4'h1, en=1 -> state sequence has period exactly 15 and visits all 15 nonzero values before repeating.
- After the first word, hold out_ready=0 for 20 cycles -> out_valid stays 1, out_data stays 8'hFE-based, r and state frozen; raise out_ready -> streaming resumes with the next bit and the stream matches an unstalled golden model.
- seed_load=1, seed_chan=2, seed_value=0 during stepping -> channel 2 state becomes 1; other channels match the model; an out-of-range seed_chan changes nothing.
- Reseed a channel on the same cycle its word completes -> the completed word uses the old MSB and the following bits come from the new seed.
- Assert nRST=0 mid-word (cnt=5, out_valid=1) -> next cycle all outputs are 0, state_i = SEED^i, and the first post-reset word equals the first word after the initial reset.
